// File: rtl/apu_pkg.sv
// apu_pkg: shared APU constants for the noise channel envelope.
package apu_pkg;
  localparam int NR42_VOL_W = 4;
  localparam int NR42_PER_W = 3;
  localparam logic [NR42_VOL_W-1:0] VOL_MAX = 4'd15;
  localparam logic [NR42_PER_W-1:0] ENV_PERIOD0_RELOAD = 3'd7;
endpackage

// File: rtl/noise_envelope_if.sv
// noise_envelope_if: NR42/strobe inputs and amplitude outputs of the envelope stage.
interface noise_envelope_if #(parameter int VOL_W = 4, parameter int PER_W = 3);
  logic envClk;
  logic trigger;
  logic [VOL_W-1:0] startVol;
  logic envAdd;
  logic [PER_W-1:0] envPeriod;
  logic noiseIn;
  logic [VOL_W-1:0] volume;
  logic dacEnable;
  logic [VOL_W-1:0] sample;
  modport master(output envClk, trigger, startVol, envAdd, envPeriod, noiseIn, input volume, dacEnable, sample);
  modport slave(input envClk, trigger, startVol, envAdd, envPeriod, noiseIn, output volume, dacEnable, sample);
endinterface

// File: rtl/noise_envelope_period_counter.sv
// env_period_counter: envelope period timer, pulses o_step combinationally on the expiring tick.
module env_period_counter
  import apu_pkg::*;
#(
  parameter int PER_W = NR42_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_tick,
  input  logic [PER_W-1:0] i_period,
  output logic             o_step
);
  logic [PER_W-1:0] r_timer;
  assign o_step = i_tick && (r_timer <= PER_W'(1));
  always_ff @(posedge clk) begin
    if (reset) r_timer <= '0;
    else if (i_load) r_timer <= (i_period == '0) ? ENV_PERIOD0_RELOAD : i_period;
    else if (i_tick) r_timer <= o_step ? i_period : r_timer - 1'b1;
  end
endmodule

// File: rtl/noise_envelope.sv
// noise_envelope: 64 Hz volume envelope, DAC enable and registered amplitude output.
module noise_envelope
  import apu_pkg::*;
#(
  parameter int VOL_W = NR42_VOL_W,
  parameter int PER_W = NR42_PER_W
) (
  input logic clk,
  input logic reset,
  noise_envelope_if.slave bus
);
  logic [VOL_W-1:0] r_vol, r_sample, w_vol_next;
  logic r_running, r_dac;
  logic w_tick, w_step, w_up, w_dn, w_run_next, w_dac_next;
  // A frozen envelope (period 0) never ticks, so the timer and volume hold.
  assign w_tick = bus.envClk && !bus.trigger && r_running && (bus.envPeriod != '0);
  env_period_counter #(.PER_W(PER_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .i_load(bus.trigger),
    .i_tick(w_tick),
    .i_period(bus.envPeriod),
    .o_step(w_step)
  );
  assign w_up = bus.envAdd && (r_vol != VOL_MAX);
  assign w_dn = !bus.envAdd && (r_vol != '0);
  always_comb begin
    w_vol_next = bus.trigger ? bus.startVol : (w_step && w_up) ? r_vol + 1'b1 : (w_step && w_dn) ? r_vol - 1'b1 : r_vol;
    w_run_next = bus.trigger ? 1'b1 : (w_step && !w_up && !w_dn) ? 1'b0 : r_running;
    w_dac_next = (bus.startVol != '0) || bus.envAdd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vol     <= '0;
      r_running <= 1'b0;
      r_dac     <= 1'b0;
      r_sample  <= '0;
    end else begin
      r_vol     <= w_vol_next;
      r_running <= w_run_next;
      r_dac     <= w_dac_next;
      r_sample  <= (w_dac_next && bus.noiseIn) ? w_vol_next : '0;
    end
  end
  assign bus.volume    = r_vol;
  assign bus.dacEnable = r_dac;
  assign bus.sample    = r_sample;
endmodule

// File: tb/tb_noise_envelope.sv
// tb_noise_envelope: table-driven vectors plus hand sequences, checked through an expectation queue.
module tb_noise_envelope;
  typedef struct {
    logic trig, env;
    logic [3:0] sv;
    logic add;
    logic [2:0] per;
    logic noise;
    logic [3:0] vol;
    logic dac;
    logic [3:0] smp;
    string name;
  } vec_t;
  typedef struct {
    logic [3:0] vol;
    logic dac;
    logic [3:0] smp;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  exp_t sb[$];
  noise_envelope_if #(.VOL_W(4), .PER_W(3)) bus ();
  noise_envelope #(.VOL_W(4), .PER_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t v(logic t, logic e, logic [3:0] sv, logic a, logic [2:0] p, logic n,
                             logic [3:0] ev, logic ed, logic [3:0] es, string nm);
    vec_t r;
    r.trig = t; r.env = e; r.sv = sv; r.add = a; r.per = p; r.noise = n;
    r.vol = ev; r.dac = ed; r.smp = es; r.name = nm;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, input vec_t x);
    exp_t e;
    reset = r;
    bus.trigger = x.trig;
    bus.envClk = x.env;
    bus.startVol = x.sv;
    bus.envAdd = x.add;
    bus.envPeriod = x.per;
    bus.noiseIn = x.noise;
    sb.push_back('{x.vol, x.dac, x.smp, x.name});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".volume"}, bus.volume, e.vol);
    chk({e.name, ".dacEnable"}, {3'b0, bus.dacEnable}, {3'b0, e.dac});
    chk({e.name, ".sample"}, bus.sample, e.smp);
  endtask
  initial begin
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, "idle_noise1"));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_noise0"));
    tbl.push_back(v(1, 0, 3, 0, 1, 1, 3, 1, 3, "dec_trig"));
    tbl.push_back(v(0, 1, 3, 0, 1, 1, 2, 1, 2, "dec_env1"));
    tbl.push_back(v(0, 1, 3, 0, 1, 0, 1, 1, 0, "dec_env2"));
    tbl.push_back(v(0, 1, 3, 0, 1, 1, 0, 1, 0, "dec_env3"));
    tbl.push_back(v(0, 1, 3, 0, 1, 1, 0, 1, 0, "dec_floor"));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, "mute_trig"));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, "mute_n0"));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, "mute_n1"));
    tbl.push_back(v(1, 1, 8, 0, 1, 1, 8, 1, 8, "trig_env"));
    tbl.push_back(v(0, 1, 8, 0, 1, 1, 7, 1, 7, "trig_env_next"));
    tbl.push_back(v(0, 0, 8, 0, 3, 1, 7, 1, 7, "per_change"));
    tbl.push_back(v(0, 1, 8, 0, 3, 1, 6, 1, 6, "per_step_old"));
    tbl.push_back(v(0, 1, 8, 0, 3, 1, 6, 1, 6, "per_new_a"));
    tbl.push_back(v(0, 1, 8, 0, 3, 1, 6, 1, 6, "per_new_b"));
    tbl.push_back(v(0, 1, 8, 0, 3, 1, 5, 1, 5, "per_new_step"));
    tbl.push_back(v(0, 0, 8, 1, 3, 1, 5, 1, 5, "add_change"));
    tbl.push_back(v(0, 1, 8, 1, 3, 1, 5, 1, 5, "add_a"));
    tbl.push_back(v(0, 1, 8, 1, 3, 1, 5, 1, 5, "add_b"));
    tbl.push_back(v(0, 1, 8, 1, 3, 1, 6, 1, 6, "add_step"));
    tbl.push_back(v(0, 0, 0, 0, 3, 1, 6, 0, 0, "dac_off"));
    tbl.push_back(v(0, 0, 0, 1, 3, 1, 6, 1, 6, "dac_on_add"));
    drive(1, v(0, 0, 0, 0, 0, 1, 0, 0, 0, "reset_hold"));
    drive(1, v(0, 0, 0, 0, 0, 1, 0, 0, 0, "reset_state"));
    foreach (tbl[i]) drive(0, tbl[i]);
    drive(0, v(1, 0, 4, 1, 2, 1, 4, 1, 4, "inc_trig"));
    for (int k = 1; k <= 26; k++) begin
      int e;
      e = (4 + k / 2 > 15) ? 15 : 4 + k / 2;
      drive(0, v(0, 1, 4, 1, 2, 1, 4'(e), 1, 4'(e), $sformatf("inc_env%0d", k)));
    end
    drive(0, v(1, 0, 9, 0, 0, 1, 9, 1, 9, "frz_trig"));
    for (int k = 1; k <= 50; k++)
      drive(0, v(0, 1, 9, 0, 0, 1, 9, 1, 9, $sformatf("frz_env%0d", k)));
    drive(0, v(1, 0, 4, 0, 1, 1, 4, 1, 4, "rst_trig"));
    drive(0, v(0, 1, 4, 0, 1, 1, 3, 1, 3, "rst_env"));
    drive(1, v(1, 1, 4, 0, 1, 1, 0, 0, 0, "rst_mid"));
    drive(0, v(0, 0, 4, 0, 1, 1, 0, 1, 0, "rst_after"));
    drive(0, v(0, 1, 4, 0, 1, 1, 0, 1, 0, "rst_env_idle"));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noise_envelope.md
# noise_envelope

Volume-envelope and output stage placed directly downstream of the noise channel. Consumes the channel's 1-bit gated noise output together with the NR42 fields (starting volume, envelope direction, envelope period) and the channel trigger. Produces a registered 4-bit amplitude sample for the mixer. Implements the 64 Hz volume sweep, the DAC-enable rule and saturation at volume 0/15.

## Interface

Parameters:
- `VOL_W`, default 4: volume/sample width; fixed at 4 for Game Boy behaviour.
- `PER_W`, default 3: envelope period width.

Ports:
- `clk`  in  1  system clock (same clock as the noise channel's `clk`).
- `reset`  in  1  synchronous, active-high reset.
- `envClk`  in  1  one-`clk`-wide strobe at 64 Hz from the frame sequencer.
- `trigger`  in  1  one-`clk`-wide NR44 trigger strobe, shared with the noise channel.
- `startVol`  in  4  NR42 VVVV, initial volume.
- `envAdd`  in  1  NR42 A: 1 = increase, 0 = decrease.
- `envPeriod`  in  3  NR42 PPP; 0 = envelope frozen.
- `noiseIn`  in  1  gated noise bit from the noise channel (already masked by length enable).
- `volume`  out  4  current envelope volume.
- `dacEnable`  out  1  DAC power state.
- `sample`  out  4  amplitude to the mixer.

## Operation

- State:
  - `vol` [3:0], drives `volume`.
  - `timer` [2:0].
  - `running` (envelope still stepping).
- Trigger, highest priority:
  - `vol` <= `startVol`.
  - `timer` <= `envPeriod`, or 7 when `envPeriod`==0.
  - `running` <= 1.
- `envClk` strobe, when `trigger` is low, `running`==1 and `envPeriod`!=0:
  - If `timer` > 1: `timer` <= `timer` − 1.
  - If `timer` <= 1: `timer` <= `envPeriod`, then:
    - `envAdd`=1 and `vol`<15: `vol`+1.
    - `envAdd`=0 and `vol`>0: `vol`−1.
    - Otherwise (would leave 0..15): `vol` held, `running` <= 0 until the next trigger.
- `envPeriod`==0 outside a trigger: `timer`, `vol` and `running` all hold.
- NR42 fields change without a trigger: no reload. The new `envPeriod`/`envAdd` take effect at the next `timer` reload or step decision.
- `dacEnable`: registered, `(startVol != 0) || envAdd`, updated every cycle.
- `sample`: registered, `dacEnable_next && noiseIn ? vol_next : 0`. It reflects the same-cycle `vol` update, so a trigger and its first sample appear together.
- `dacEnable`==0 forces `sample`=0 regardless of `vol`.
- All arithmetic is unsigned 4-bit. Wrap-around never occurs; saturation is handled by the `running` clear.

## Timing

- Reset values: `vol`=0, `timer`=0, `running`=0, `volume`=0, `dacEnable`=0, `sample`=0.
- Reset mid-envelope takes effect on the next edge and discards all state. `trigger` or `envClk` asserted together with `reset` is ignored.
- Latency:
  - `trigger` → `volume`=`startVol`: 1 clk edge.
  - `noiseIn` → `sample`: 1 clk edge.
  - `envClk` → volume step: 1 edge.
- `trigger` and `envClk` in the same cycle: the trigger wins and the `envClk` is dropped. The first step therefore lands `envPeriod` envClk strobes later.
- Strobes longer than one `clk` count once per cycle high. Upstream guarantees single-cycle pulses.
- No handshake: the block is a pure strobe consumer.

## Structure

- Shared package `apu_pkg`:
  - `VOL_MAX` = 4'd15.
  - `ENV_PERIOD0_RELOAD` = 3'd7.
  - `NR42` field widths.
- One sub-module, `env_period_counter`, is natural. It holds `timer`, takes `load`, `tick` and `period` inputs, and emits a one-cycle `step` pulse on expiry. The parent holds `vol`, `running`, the DAC logic and the output register.
- The channel top instantiates `noiseChannel` and `noise_envelope` side by side, sharing `trigger`.

## Test plan

- Reset release, `noiseIn`=1, no trigger → `volume`=0, `dacEnable`=0, `sample`=0.
- `startVol`=4, `envAdd`=1, `envPeriod`=2, trigger, `noiseIn`=1:
  - `sample`=4 one edge after the trigger.
  - After 2 envClks: `volume`=5. After 22 envClks: `volume`=15.
  - Further envClks: `volume` stays 15 and `running`=0.
- `startVol`=3, `envAdd`=0, `envPeriod`=1, trigger → 3 envClks give `volume` 2, 1, 0; a 4th envClk leaves it at 0. `dacEnable`=1 throughout.
- `startVol`=0, `envAdd`=0, trigger, `noiseIn` toggling → `dacEnable`=0, `sample`=0 constantly.
- `envPeriod`=0, `startVol`=9, trigger, 50 envClks → `volume`=9 throughout.
- Simultaneous cases:
  - `trigger` with `envClk` (`envPeriod`=1, `startVol`=8, `envAdd`=0) → `volume`=8 after that edge, and 7 after the next envClk.
  - `reset` during a running envelope → all outputs 0 on the next edge.
